// File: rtl/pulse_line_rx_if.sv
// Signal bundle for pulse_line_rx: field line and clear in, deglitched state, edge pulses and event count out.
interface pulse_line_rx_if #(
   parameter int CNT_W = 16
);
   logic             a_n;
   logic             clr;
   logic             level;
   logic             rise;
   logic             fall;
   logic [CNT_W-1:0] count;
   logic             ovf;

   modport master (output a_n, clr, input level, rise, fall, count, ovf);
   modport slave  (input a_n, clr, output level, rise, fall, count, ovf);
endinterface

// File: rtl/pulse_line_rx.sv
// Synchronizes and deglitches an active-low field line, emits edge pulses and a saturating event count.
// Optional macro PULSE_LINE_RX_BOTH_EDGES_EN: count falling edges as well as rising edges.
module pulse_line_rx #(
   parameter int FILT_LEN = 4,
   parameter int CNT_W    = 16
) (
   input logic            clk,
   input logic            rst,
   pulse_line_rx_if.slave bus
);
   localparam int               RUN_W    = $clog2(FILT_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
   localparam bit               DIRECT   = (FILT_LEN == 1);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_CHK_HIGH,
      ST_HIGH,
      ST_CHK_LOW
   } state_t;

   state_t           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [1:0]       sync_q;
   logic             s;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Synchronizer resets to the idle (high) line level so no edge is seen after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], bus.a_n};
   end

   assign s = ~sync_q[1];

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               if (DIRECT) begin
                  state_d = ST_HIGH;
                  run_d   = '0;
               end else begin
                  state_d = ST_CHK_HIGH;
                  run_d   = RUN_ONE;
               end
            end
         end
         ST_CHK_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;
               run_d   = '0;
            end else if (run_q == RUN_LAST) begin
               state_d = ST_HIGH;
               run_d   = '0;
            end else begin
               run_d = run_q + RUN_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               if (DIRECT) begin
                  state_d = ST_LOW;
                  run_d   = '0;
               end else begin
                  state_d = ST_CHK_LOW;
                  run_d   = RUN_ONE;
               end
            end
         end
         ST_CHK_LOW: begin
            if (s) begin
               state_d = ST_HIGH;
               run_d   = '0;
            end else if (run_q == RUN_LAST) begin
               state_d = ST_LOW;
               run_d   = '0;
            end else begin
               run_d = run_q + RUN_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            run_d   = '0;
         end
      endcase
   end

   assign level_d = (state_q == ST_HIGH) || (state_q == ST_CHK_LOW);
   assign rise_d  = level_d & ~level_q;
   assign fall_d  = ~level_d & level_q;

`ifdef PULSE_LINE_RX_BOTH_EDGES_EN
   assign inc = rise_q | fall_q;
`else
   assign inc = rise_q;
`endif

   // Clear wins over saturation; a coincident event still counts as the first one.
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
         count_d = inc ? CNT_W'(1) : '0;
         ovf_d   = 1'b0;
      end else if (inc) begin
         count_d = sat_inc(count_q);
         if (&count_q) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOW;
         run_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.level = level_q;
   assign bus.rise  = rise_q;
   assign bus.fall  = fall_q;
   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;
endmodule
